// File: rtl/mem_bus_controller_pkg.sv
// Shared constants and state encoding for the CPU memory bus sequencer.
// Counter width helper keeps the wait counter just wide enough to hold the limit.
package mem_bus_controller_pkg;

  localparam int MBC_WORD_SIZE = 16;
  localparam int MBC_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } mbc_state_e;

  function automatic int mbc_cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_bus_controller_wait_counter.sv
// Saturating handshake wait counter with synchronous clear and enable.
// o_expire flags the cycle in which one more unanswered cycle reaches LIMIT.
module mem_bus_controller_wait_counter
  import mem_bus_controller_pkg::*;
#(
  parameter int LIMIT = MBC_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = mbc_cnt_width(LIMIT);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  generate
    if (LIMIT == 0) begin : g_no_limit
      assign o_expire = 1'b0;
    end else begin : g_limit
      localparam logic [W:0] LIMIT_W = (W + 1)'(LIMIT);
      logic [W:0] w_inc;
      assign w_inc    = {1'b0, r_count} + (W + 1)'(1);
      assign o_expire = (w_inc >= LIMIT_W);
    end
  endgenerate

endmodule

// File: rtl/mem_bus_controller.sv
// Shared memory bus sequencer: arbitrates fetch and load/store requesters and
// runs the readM/inputReady and writeM/ackOutput handshakes with a timeout.
module mem_bus_controller
  import mem_bus_controller_pkg::*;
#(
  parameter int WORD_SIZE = MBC_WORD_SIZE,
  parameter int TIMEOUT   = MBC_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_done,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 busy,
  output logic                 bus_err,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  mbc_state_e r_state, w_state_next;

  logic                 r_read_m, w_read_next;
  logic                 r_write_m, w_write_next;
  logic [WORD_SIZE-1:0] r_address, w_address_next;
  logic [WORD_SIZE-1:0] r_wdata, w_wdata_next;
  logic [WORD_SIZE-1:0] r_if_rdata, w_if_rdata_next;
  logic [WORD_SIZE-1:0] r_d_rdata, w_d_rdata_next;
  logic                 r_if_done, w_if_done_next;
  logic                 r_d_done, w_d_done_next;
  logic                 r_bus_err, w_bus_err_next;
  logic                 w_cnt_clr, w_cnt_en, w_expire;

  mem_bus_controller_wait_counter #(
    .LIMIT (TIMEOUT)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next    = r_state;
    w_read_next     = r_read_m;
    w_write_next    = r_write_m;
    w_address_next  = r_address;
    w_wdata_next    = r_wdata;
    w_if_rdata_next = r_if_rdata;
    w_d_rdata_next  = r_d_rdata;
    w_if_done_next  = 1'b0;
    w_d_done_next   = 1'b0;
    w_bus_err_next  = r_bus_err;
    w_cnt_clr       = 1'b0;
    w_cnt_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Holding off while a done pulse is out lets the requester drop or
        // change its request before it could be granted again.
        if (!r_if_done && !r_d_done) begin
          if (d_write) begin
            w_state_next   = ST_STORE;
            w_write_next   = 1'b1;
            w_address_next = d_addr;
            w_wdata_next   = d_wdata;
            w_cnt_clr      = 1'b1;
          end else if (d_read) begin
            w_state_next   = ST_LOAD;
            w_read_next    = 1'b1;
            w_address_next = d_addr;
            w_cnt_clr      = 1'b1;
          end else if (if_req) begin
            w_state_next   = ST_FETCH;
            w_read_next    = 1'b1;
            w_address_next = if_addr;
            w_cnt_clr      = 1'b1;
          end
        end
      end

      ST_FETCH, ST_LOAD: begin
        if (inputReady) begin
          w_read_next  = 1'b0;
          w_state_next = ST_IDLE;
          if (r_state == ST_FETCH) begin
            w_if_rdata_next = data;
            w_if_done_next  = 1'b1;
          end else begin
            w_d_rdata_next = data;
            w_d_done_next  = 1'b1;
          end
        end else if (w_expire) begin
          // Abort leaves the previous read data in place.
          w_read_next    = 1'b0;
          w_state_next   = ST_IDLE;
          w_bus_err_next = 1'b1;
          if (r_state == ST_FETCH) begin
            w_if_done_next = 1'b1;
          end else begin
            w_d_done_next = 1'b1;
          end
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      ST_STORE: begin
        if (ackOutput) begin
          w_write_next  = 1'b0;
          w_state_next  = ST_IDLE;
          w_d_done_next = 1'b1;
        end else if (w_expire) begin
          w_write_next   = 1'b0;
          w_state_next   = ST_IDLE;
          w_bus_err_next = 1'b1;
          w_d_done_next  = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_read_m   <= 1'b0;
      r_write_m  <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_read_m   <= w_read_next;
      r_write_m  <= w_write_next;
      r_address  <= w_address_next;
      r_wdata    <= w_wdata_next;
      r_if_rdata <= w_if_rdata_next;
      r_d_rdata  <= w_d_rdata_next;
      r_if_done  <= w_if_done_next;
      r_d_done   <= w_d_done_next;
      r_bus_err  <= w_bus_err_next;
    end
  end

  // writeM doubles as the bus output enable, so data is released with it.
  assign data     = r_write_m ? r_wdata : 'z;
  assign readM    = r_read_m;
  assign writeM   = r_write_m;
  assign address  = r_address;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign if_done  = r_if_done;
  assign d_done   = r_d_done;
  assign bus_err  = r_bus_err;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_controller.sv
// Randomized scoreboard bench for mem_bus_controller against a memory responder
// and a transaction-level reference model of arbitration, latency and timeout.
module tb_mem_bus_controller;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        busy;
  logic        bus_err;
  logic        readM;
  logic        writeM;
  logic [15:0] address;
  wire  [15:0] data;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;
  logic        mem_drive = 1'b0;
  logic [15:0] mem_dout = '0;

  assign data = mem_drive ? mem_dout : 'z;

  always #5 clk = ~clk;

  mem_bus_controller #(.WORD_SIZE(16), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .busy(busy), .bus_err(bus_err),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .ackOutput(ackOutput)
  );

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [15:0] rdata;
    logic        err;
    logic        ok;
    int          cyc;
    logic [15:0] addr;
    logic [15:0] wdata;
  } item_t;

  item_t       sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  // Memory image seen by the responder and the model's own copy of it.
  logic [15:0] mem_arr   [logic [15:0]];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] m_if_rdata = '0;
  logic [15:0] m_d_rdata = '0;
  logic        m_err = 1'b0;

  int          mem_lat = 1;
  logic        force_ir = 1'b0;
  logic [15:0] force_data = '0;
  logic [15:0] wr_addr_seen = '0;
  logic [15:0] wr_data_seen = '0;
  logic [15:0] pool [8];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] img(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'hC35A;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : img(a);
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : img(a);
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%04h required=%04h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Memory responder: answers the k-th strobe cycle, throws in stray handshakes
  // of the wrong kind, and records what each acknowledged store put on the bus.
  int rcnt = 0;
  initial forever begin
    @(posedge clk);
    #2;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    mem_drive  = 1'b0;
    if (readM || writeM) rcnt++; else rcnt = 0;
    if (force_ir) begin
      inputReady = 1'b1;
      mem_drive  = 1'b1;
      mem_dout   = force_data;
    end else if (readM) begin
      ackOutput = 1'($urandom % 2);
      if (rcnt == mem_lat) begin
        inputReady = 1'b1;
        mem_drive  = 1'b1;
        mem_dout   = mem_rd(address);
      end
    end else if (writeM) begin
      inputReady = 1'($urandom % 2);
      if (rcnt == mem_lat) begin
        ackOutput         = 1'b1;
        mem_arr[address]  = data;
        wr_addr_seen      = address;
        wr_data_seen      = data;
      end
    end
  end

  task automatic check_item(input logic isdata);
    item_t it;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
    end else begin
      it = sbq.pop_front();
      chkb("done_kind", isdata, (it.kind != 0));
      chk16("rdata", isdata ? d_rdata : if_rdata, it.rdata);
      chkb("bus_err", bus_err, it.err);
      chki("done_cycle", cyc, it.cyc);
      chkb("strobes_low", readM | writeM, 1'b0);
      chkb("busy_at_done", busy, 1'b0);
      if (it.kind == 2 && it.ok) begin
        chk16("store_addr", wr_addr_seen, it.addr);
        chk16("store_data", wr_data_seen, it.wdata);
      end
      $display("txn kind=%0d addr=%04h rdata=%04h err=%0b cyc=%0d", it.kind,
               it.addr, isdata ? d_rdata : if_rdata, bus_err, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset && (if_done || d_done)) begin
      if (if_done && d_done) begin
        checks++;
        errors++;
        $display("FAIL both_done actual=11 required=one_of");
      end
      if (d_done) check_item(1'b1);
      if (if_done) check_item(1'b0);
    end
  end

  // One request set issued together; the model orders it data-op first, then fetch.
  task automatic do_txn(input logic f, input logic r, input logic w,
                        input logic [15:0] ia, input logic [15:0] da,
                        input logic [15:0] wd, input int k);
    int    eff;
    logic  ok;
    int    c;
    int    nxt;
    int    n;
    item_t it;
    @(negedge clk);
    eff     = (k > T) ? T : k;
    ok      = (k <= T);
    mem_lat = k;
    c       = cyc;
    nxt     = c + 1 + eff;
    if (r || w) begin
      it.kind  = w ? 2 : 1;
      it.addr  = da;
      it.wdata = wd;
      it.ok    = ok;
      if (!w && ok) m_d_rdata = model_rd(da);
      if (w && ok) model_mem[da] = wd;
      if (!ok) m_err = 1'b1;
      it.rdata = m_d_rdata;
      it.err   = m_err;
      it.cyc   = nxt;
      sbq.push_back(it);
      nxt = nxt + 2 + eff;
    end
    if (f) begin
      it.kind  = 0;
      it.addr  = ia;
      it.wdata = '0;
      it.ok    = ok;
      if (ok) m_if_rdata = model_rd(ia);
      else m_err = 1'b1;
      it.rdata = m_if_rdata;
      it.err   = m_err;
      it.cyc   = nxt;
      sbq.push_back(it);
    end
    if_addr = ia;
    d_addr  = da;
    d_wdata = wd;
    if_req  = f;
    d_read  = r;
    d_write = w;
    n = 0;
    while ((if_req || d_read || d_write) && n < 60) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        d_addr  = 16'($urandom);
        d_wdata = 16'($urandom);
        if (!(r || w)) if_addr = 16'($urandom);
      end
      if (d_done) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      if (if_done) if_req = 1'b0;
    end
    if (if_req || d_read || d_write) begin
      checks++;
      errors++;
      $display("FAIL txn_no_done actual=pending required=done");
      if_req  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  initial begin
    int          c;
    int          n;
    int          i;
    logic [2:0]  fl;
    item_t       it;
    logic [15:0] baddr [4];

    pool[0] = 16'h0010;
    pool[1] = 16'h0020;
    for (int j = 2; j < 8; j++) pool[j] = 16'($urandom);
    mem_arr[16'h0010]   = 16'h6A05;
    model_mem[16'h0010] = 16'h6A05;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chkb("rst_readM", readM, 1'b0);
    chkb("rst_writeM", writeM, 1'b0);
    chk16("rst_address", address, 16'h0000);
    chk16("rst_if_rdata", if_rdata, 16'h0000);
    chk16("rst_d_rdata", d_rdata, 16'h0000);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_bus_err", bus_err, 1'b0);

    do_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 3);
    do_txn(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'hBEEF, 2);
    do_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000, 1);
    do_txn(1'b1, 1'b1, 1'b0, pool[3], pool[4], 16'h0000, 2);
    do_txn(1'b1, 1'b1, 1'b1, pool[5], pool[6], 16'h1357, 1);

    // Fetch held through done with an immediately answering memory.
    @(negedge clk);
    mem_lat = 1;
    c = cyc;
    for (int j = 0; j < 4; j++) begin
      baddr[j] = pool[j + 2];
      m_if_rdata = model_rd(baddr[j]);
      it.kind = 0; it.addr = baddr[j]; it.wdata = '0; it.ok = 1'b1;
      it.rdata = m_if_rdata; it.err = m_err; it.cyc = c + 2 + 3 * j;
      sbq.push_back(it);
    end
    if_addr = baddr[0];
    if_req  = 1'b1;
    i = 0;
    n = 0;
    while (i < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (if_done) begin
        i++;
        if (i == 4) if_req = 1'b0;
        else if_addr = baddr[i];
      end
    end
    chki("b2b_count", i, 4);
    if_req = 1'b0;

    for (int j = 0; j < 40; j++) begin
      do fl = 3'($urandom); while (fl == 3'b000);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      do_txn(fl[0], fl[1], fl[2], pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
             16'($urandom), $urandom_range(1, 5));
    end

    // Memory never answers: abort, then a late inputReady must be ignored.
    do_txn(1'b0, 1'b1, 1'b0, 16'h0000, pool[2], 16'h0000, 99);
    @(negedge clk);
    force_data = ~m_d_rdata;
    force_ir   = 1'b1;
    @(negedge clk);
    force_ir = 1'b0;
    @(negedge clk);
    chk16("d_rdata_after_abort", d_rdata, m_d_rdata);
    chkb("bus_err_sticky", bus_err, 1'b1);

    // Asynchronous reset in the middle of a store.
    @(negedge clk);
    mem_lat = 99;
    d_addr  = pool[1];
    d_wdata = 16'h5555;
    d_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chkb("store_writeM", writeM, 1'b1);
    chkb("store_busy", busy, 1'b1);
    chk16("store_bus_data", data, 16'h5555);
    #2 reset = 1'b1;
    #1;
    chkb("arst_writeM", writeM, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    chkb("arst_bus_err", bus_err, 1'b0);
    chk16("arst_address", address, 16'h0000);
    d_write    = 1'b0;
    m_err      = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk16("arst_d_rdata", d_rdata, 16'h0000);

    do_txn(1'b0, 1'b1, 1'b0, 16'h0000, pool[1], 16'h0000, 1);
    do_txn(1'b1, 1'b0, 1'b0, pool[7], 16'h0000, 16'h0000, 4);

    n = 0;
    while (sbq.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chki("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_controller.md
Name: mem_bus_controller

Overview:
- Multi-cycle sequencer owning the CPU's single shared memory bus: readM, writeM, address, bidirectional data, inputReady, ackOutput.
- Arbitrates between two requesters, instruction fetch and data load/store, and runs the memory handshake.
- Returns read data with a one-cycle done pulse per requester.
- Sits between the CPU core datapath and the external memory model, replacing direct bus driving by the fetch and data-memory blocks.

Parameters:
- WORD_SIZE, 16, width of address and data words.
- TIMEOUT, 255, maximum wait cycles for a handshake before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- if_req  input  1  instruction fetch request (level, held until if_done).
- if_addr  input  WORD_SIZE  fetch address (PC).
- if_rdata  output  WORD_SIZE  fetched instruction, registered.
- if_done  output  1  one-cycle pulse: fetch complete, if_rdata valid.
- d_read  input  1  data load request (level).
- d_write  input  1  data store request (level).
- d_addr  input  WORD_SIZE  data address (ALU result).
- d_wdata  input  WORD_SIZE  store data.
- d_rdata  output  WORD_SIZE  loaded data, registered.
- d_done  output  1  one-cycle pulse: load or store complete.
- busy  output  1  high while state is not IDLE.
- bus_err  output  1  sticky timeout flag.
- readM  output  1  memory read strobe.
- writeM  output  1  memory write strobe.
- address  output  WORD_SIZE  memory address.
- data  inout  WORD_SIZE  memory data bus; driven only in STORE, else high-Z.
- inputReady  input  1  memory read data valid.
- ackOutput  input  1  memory write accepted.

Behaviour:
- Reset (async, immediate, including mid-transaction):
  - state = IDLE; readM = writeM = 0; address = 0; data = Z.
  - if_rdata = d_rdata = 0; if_done = d_done = 0; bus_err = 0; wait counter = 0.
- States: IDLE, FETCH, LOAD, STORE. All outputs are registered.
- IDLE grant rule, evaluated only when if_done and d_done are both low that cycle:
  - Priority: d_write → STORE; else d_read → LOAD; else if_req → FETCH.
  - At grant, latch the address (and d_wdata for STORE). readM or writeM rises the cycle after the request is sampled.
- Simultaneous d_read and d_write: illegal; the write is served and the read is ignored.
- FETCH/LOAD:
  - readM = 1; address = latched address.
  - On a posedge with inputReady = 1: capture data into if_rdata (FETCH) or d_rdata (LOAD); pulse the matching done for exactly one cycle; readM = 0; go to IDLE.
  - ackOutput is ignored in these states.
- STORE:
  - writeM = 1; data driven with latched wdata for the whole state.
  - On a posedge with ackOutput = 1: pulse d_done; writeM = 0; data = Z; go to IDLE.
  - inputReady is ignored in STORE.
- Minimum latency: request to done = 2 cycles when memory responds in the first strobe cycle.
  - A done cycle is always followed by at least one IDLE cycle before the next strobe.
  - Minimum back-to-back spacing is 3 cycles.
- Requester protocol: hold the request until done; deassert in the cycle after done is seen or issue the next request. Requests held through done are regranted.
- Wait counter:
  - Clears on grant; increments each cycle in FETCH/LOAD/STORE without a handshake.
  - If TIMEOUT ≠ 0 and the counter reaches TIMEOUT: abort, set bus_err = 1 (sticky until reset), pulse the matching done, leave rdata unchanged, drop strobes and release data, go to IDLE.
  - Handshakes arriving after an abort are ignored.
  - The counter saturates and must not wrap.
- Requests changing while active: ignored. The transaction completes on the latched address/data.

Decomposition:
- Shared package/include: state encodings (IDLE, FETCH, LOAD, STORE), WORD_SIZE (existing opcodes include), default TIMEOUT constant.
- No sub-module required. An optional mem_wait_counter (saturating counter with clear/enable/limit) is natural if reused elsewhere.

Test Plan:
- Fetch: assert reset, release; if_req = 1, if_addr = 0x0010; memory raises inputReady with data 0x6A05 after 3 cycles → readM high for 3 cycles, address = 0x0010; if_rdata = 0x6A05; single-cycle if_done; readM low next cycle.
- Store: d_write = 1, d_addr = 0x0020, d_wdata = 0xBEEF; ackOutput after 2 cycles → writeM high, data = 0xBEEF while in STORE; d_done pulse; data = Z afterward.
- Arbitration: if_req and d_read asserted in the same IDLE cycle → LOAD first (d_done); FETCH granted after the one-cycle IDLE gap; if_done follows.
- Timeout with TIMEOUT = 4: d_read, memory never responds → readM high 4 cycles, then d_done pulse, bus_err = 1 and stays 1; a later inputReady pulse has no effect on d_rdata.
- Reset mid-op: assert reset during STORE with data driven → same cycle, asynchronously: writeM = 0, data = Z, busy = 0, bus_err = 0.
- Back-to-back fetches: if_req held high, memory responds immediately → if_done pulses every 3 cycles; if_rdata updates each time.
